alu_op_sequencer: RTL

//  Issue controller in front of the shared 32-bit ALU. Accepts one operation at a time from the execute stage

---
 rtl/alu_op_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Issue controller for the shared 32-bit ALU: registered single-cycle ops plus a 32-step restoring divider.
// Optional feature macro: DIV_ZERO_TRAP_EN (short-circuits DIV by zero and adds the div_by_zero output).
module alu_op_sequencer #(
  parameter int WIDTH    = 32,
  parameter int DIV_ITER = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [1:0]       alu_flags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [1:0]       resp_flags,
  output logic             busy
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam logic [4:0] OP_DIV = 5'b01000;
  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DIV_RUN, DONE} state_t;

  state_t           state, state_next;
  logic             ready_reg, resp_valid_reg;
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
  logic [4:0]       alu_opcode_reg;
  logic [WIDTH-1:0] resp_data_reg;
  logic [1:0]       resp_flags_reg;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quot, divisor;
  logic [CNT_W-1:0] iter;
  logic             accept, is_div, trap_zero;
  logic [WIDTH:0]   rem_shift, rem_step;
  logic [WIDTH-1:0] quot_shift, quot_step;

  assign accept = req_valid && ready_reg;
  assign is_div = (req_opcode == OP_DIV);

`ifdef DIV_ZERO_TRAP_EN
  logic dbz_reg;
  assign trap_zero   = (req_b == '0);
  assign div_by_zero = dbz_reg;
`else
  assign trap_zero = 1'b0;
`endif

  assign req_ready  = ready_reg;
  assign resp_valid = resp_valid_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_opcode = alu_opcode_reg;
  assign resp_data  = resp_data_reg;
  assign resp_flags = resp_flags_reg;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_div) state_next = trap_zero ? DONE : DIV_RUN;
          else        state_next = EXEC;
        end
      end
      EXEC:    state_next = DONE;
      DIV_RUN: if (iter == ITER_LAST) state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the remainder, subtract when it fits.
  always_comb begin
    rem_shift  = (rem << 1) | {{WIDTH{1'b0}}, quot[WIDTH-1]};
    quot_shift = quot << 1;
    rem_step   = rem_shift;
    quot_step  = quot_shift;
    if (rem_shift >= {1'b0, divisor}) begin
      rem_step  = rem_shift - {1'b0, divisor};
      quot_step = quot_shift | {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_opcode_reg <= '0;
      resp_data_reg  <= '0;
      resp_flags_reg <= '0;
      rem            <= '0;
      quot           <= '0;
      divisor        <= '0;
      iter           <= '0;
`ifdef DIV_ZERO_TRAP_EN
      dbz_reg        <= 1'b0;
`endif
    end else begin
      // Handshake flags are registered so both are low while held in reset.
      ready_reg      <= (state_next == IDLE);
      resp_valid_reg <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_div) begin
              quot    <= req_a;
              divisor <= req_b;
              rem     <= '0;
              iter    <= '0;
              if (trap_zero) begin
                resp_data_reg  <= '1;
                resp_flags_reg <= 2'b00;
`ifdef DIV_ZERO_TRAP_EN
                dbz_reg        <= 1'b1;
`endif
              end
            end else begin
              alu_a_reg      <= req_a;
              alu_b_reg      <= req_b;
              alu_opcode_reg <= req_opcode;
            end
          end
        end
        EXEC: begin
          resp_data_reg  <= alu_out;
          resp_flags_reg <= alu_flags;
        end
        DIV_RUN: begin
          rem  <= rem_step;
          quot <= quot_step;
          iter <= iter + 1'b1;
          if (iter == ITER_LAST) begin
            resp_data_reg  <= quot_step;
            resp_flags_reg <= {(quot_step == '0), 1'b0};
          end
        end
        DONE: begin
`ifdef DIV_ZERO_TRAP_EN
          if (resp_ready) dbz_reg <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
